// File: rtl/hazard3_reset_sequencer.sv
// Ordered release of N reset domains with handshake and re-assert on request.
// Build option: define HAZARD3_RESET_SEQ_TIMEOUT_EN to bound each domain's ready wait.
module hazard3_reset_sequencer #(
    parameter int N_DOMAINS      = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sys_reset_req,
    output logic [N_DOMAINS-1:0] domain_rst_n,
    input  logic [N_DOMAINS-1:0] domain_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int M1  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int M2  = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int M3  = (M2 > N_DOMAINS) ? M2 : N_DOMAINS;
    localparam int CW  = $clog2(M3 + 1);
    localparam int IW  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_DOMAINS - 1);

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_ctr;
    logic [IW-1:0]        r_idx;
    logic [N_DOMAINS-1:0] r_domain_rst_n;
    logic                 r_done;
    logic                 w_advance;
    logic [IW-1:0]        w_idx_next;

    assign w_idx_next = r_idx + 1'b1;

`ifdef HAZARD3_RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic r_timeout_err;
    logic w_timeout_hit;

    // An expired wait is treated exactly like a ready arriving.
    assign w_timeout_hit = (r_ctr == TO_LAST) && !domain_ready[r_idx];
    assign w_advance     = domain_ready[r_idx] || w_timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (!sys_reset_req && (r_state == S_RELEASE) && w_timeout_hit) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_advance   = domain_ready[r_idx];
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_ASSERT;
            r_ctr          <= '0;
            r_idx          <= '0;
            r_domain_rst_n <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (sys_reset_req) begin
                r_state        <= S_ASSERT;
                r_ctr          <= '0;
                r_idx          <= '0;
                r_domain_rst_n <= '0;
            end else begin
                case (r_state)
                    S_ASSERT: begin
                        r_domain_rst_n <= '0;
                        if (r_ctr == HOLD_LAST) begin
                            r_state        <= S_RELEASE;
                            r_idx          <= '0;
                            r_domain_rst_n <= N_DOMAINS'(1);
                            r_ctr          <= '0;
                        end else begin
                            r_ctr <= r_ctr + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (w_advance) begin
                            r_ctr <= '0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= S_RUN;
                                r_done  <= 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                r_idx                      <= w_idx_next;
                                r_domain_rst_n[w_idx_next] <= 1'b1;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
`ifdef HAZARD3_RESET_SEQ_TIMEOUT_EN
                        else begin
                            r_ctr <= r_ctr + 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (r_ctr == GAP_LAST) begin
                            r_state                    <= S_RELEASE;
                            r_idx                      <= w_idx_next;
                            r_domain_rst_n[w_idx_next] <= 1'b1;
                            r_ctr                      <= '0;
                        end else begin
                            r_ctr <= r_ctr + 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_domain_rst_n <= '1;
                    end
                    default: begin
                        r_state <= S_ASSERT;
                        r_ctr   <= '0;
                    end
                endcase
            end
        end
    end

    assign domain_rst_n = r_domain_rst_n;
    assign busy         = (r_state != S_RUN);
    assign done         = r_done;

endmodule
